// File: rtl/romulator_pkg.sv
// Shared enable-table constants, header layout and writer state encoding.
// ENABLE_TABLE_CHECKSUM_EN adds the trailing checksum state.
package romulator_pkg;

  localparam int ADDR_ENTRY_BITS = 8;
  localparam int CONFIG_BITS = 4;
  localparam int ENABLE_ADDR_BITS =
    ADDR_ENTRY_BITS + CONFIG_BITS + 1;
  localparam int SLICE_BITS = ADDR_ENTRY_BITS + 1;

  localparam int HDR_CFG_LSB = 0;
  localparam int HDR_ALL_BIT = 4;
  localparam int HDR_RSV_LSB = 5;

  typedef logic [ENABLE_ADDR_BITS-1:0] tbl_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LOAD,
    ST_UNPACK,
`ifdef ENABLE_TABLE_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/enable_entry_unpacker.sv
// Splits one latched byte into four 2-bit table entries,
// LSB pair first, one registered write per cycle.
module enable_entry_unpacker (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       abort_i,
  input  logic [7:0] byte_i,
  output logic       we_o,
  output logic [1:0] data_o,
  output logic       last_o
);

  logic       we_q, we_d;
  logic [1:0] data_q, data_d;
  logic [5:0] rest_q, rest_d;
  logic [1:0] sel_q, sel_d;

  always_comb begin
    we_d = we_q;
    data_d = data_q;
    rest_d = rest_q;
    sel_d = sel_q;
    if (abort_i) begin
      we_d = 1'b0;
      sel_d = 2'd0;
    end else if (load_i) begin
      we_d = 1'b1;
      data_d = byte_i[1:0];
      rest_d = byte_i[7:2];
      sel_d = 2'd0;
    end else if (we_q) begin
      sel_d = sel_q + 2'd1;
      if (sel_q == 2'd3) begin
        we_d = 1'b0;
      end else begin
        data_d = rest_q[1:0];
        rest_d = {2'b00, rest_q[5:2]};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q <= 1'b0;
      data_q <= 2'd0;
      rest_q <= 6'd0;
      sel_q <= 2'd0;
    end else begin
      we_q <= we_d;
      data_q <= data_d;
      rest_q <= rest_d;
      sel_q <= sel_d;
    end
  end

  assign we_o = we_q;
  assign data_o = data_q;
  assign last_o = we_q & (sel_q == 2'd3);

endmodule

// File: rtl/enable_table_writer.sv
// Byte-stream loader for the RAM/bus enable table.
// ENABLE_TABLE_CHECKSUM_EN appends a zero-sum checksum byte.
module enable_table_writer
  import romulator_pkg::*;
(
  input  logic            fpga_clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            tbl_we,
  output tbl_addr_t       tbl_addr,
  output logic [1:0]      tbl_data,
  output logic            busy,
  output logic            done,
  output logic            error
);

  wr_state_e state_q, state_d;
  tbl_addr_t addr_q, addr_d;
  tbl_addr_t end_q, end_d;
  logic      err_q, err_d;
  logic      accept, load, abort, last;
  logic [CONFIG_BITS-1:0] hdr_cfg;
  logic      hdr_all, hdr_bad;
`ifdef ENABLE_TABLE_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  assign hdr_cfg = in_data[HDR_CFG_LSB +: CONFIG_BITS];
  assign hdr_all = in_data[HDR_ALL_BIT];
  assign hdr_bad = |in_data[7:HDR_RSV_LSB];
  assign accept = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    end_d = end_q;
    err_d = err_q;
    load = 1'b0;
    abort = 1'b0;
`ifdef ENABLE_TABLE_CHECKSUM_EN
    sum_d = sum_q;
`endif
    if (start) begin
      // Restart wins over any byte offered this cycle.
      state_d = ST_HEADER;
      err_d = 1'b0;
      abort = 1'b1;
    end else begin
      unique case (state_q)
        ST_HEADER: if (accept) begin
          if (hdr_bad) begin
            err_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d = hdr_all ? '0 :
              {hdr_cfg, {SLICE_BITS{1'b0}}};
            end_d = hdr_all ? '1 :
              {hdr_cfg, {SLICE_BITS{1'b1}}};
`ifdef ENABLE_TABLE_CHECKSUM_EN
            sum_d = in_data;
`endif
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: if (accept) begin
          load = 1'b1;
`ifdef ENABLE_TABLE_CHECKSUM_EN
          sum_d = sum_q + in_data;
`endif
          state_d = ST_UNPACK;
        end
        ST_UNPACK: begin
          if (last && addr_q == end_q) begin
`ifdef ENABLE_TABLE_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            // Counter stops on the end address: no wrap.
            addr_d = addr_q + 1'b1;
            if (last) state_d = ST_LOAD;
          end
        end
`ifdef ENABLE_TABLE_CHECKSUM_EN
        ST_CHECK: if (accept) begin
          if (sum_q + in_data == 8'h00) begin
            state_d = ST_DONE;
          end else begin
            err_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
`endif
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q <= '0;
      end_q <= '0;
      err_q <= 1'b0;
`ifdef ENABLE_TABLE_CHECKSUM_EN
      sum_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      end_q <= end_d;
      err_q <= err_d;
`ifdef ENABLE_TABLE_CHECKSUM_EN
      sum_q <= sum_d;
`endif
    end
  end

  enable_entry_unpacker u_unpack (
    .clk_i   (fpga_clk),
    .rst_i   (reset),
    .load_i  (load),
    .abort_i (abort),
    .byte_i  (in_data),
    .we_o    (tbl_we),
    .data_o  (tbl_data),
    .last_o  (last)
  );

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      ST_HEADER,
      ST_LOAD: in_ready = 1'b1;
`ifdef ENABLE_TABLE_CHECKSUM_EN
      ST_CHECK: in_ready = 1'b1;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign tbl_addr = addr_q;
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign error = err_q;

endmodule

// File: tb/tb_enable_table_writer.sv
// Scoreboard bench for enable_table_writer; checksum scenarios
// run when ENABLE_TABLE_CHECKSUM_EN is defined.
module tb_enable_table_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, tbl_we, busy, done, error;
  logic [12:0] tbl_addr;
  logic [1:0]  tbl_data;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_we_cyc = 0;
  int rd_idx = 0;
  logic [14:0] exp_q[$];
  logic [14:0] obs_q[$];
`ifdef ENABLE_TABLE_CHECKSUM_EN
  logic [7:0] ck_delta = 8'h00;
`endif

  always #5 clk = ~clk;

  enable_table_writer dut (
    .fpga_clk (clk),
    .reset    (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (tbl_we) begin
      wr_cnt++;
      last_we_cyc = cyc;
      obs_q.push_back({tbl_addr, tbl_data});
    end
  end

  function automatic void push_byte(
    input logic [12:0] a, input logic [7:0] b);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({a + 13'(k), b[2*k +: 2]});
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready)
      $display("FAIL send_byte: in_ready=0 required 1");
    else
      passes++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_load(input logic [7:0] hdr,
    input int n, input logic [7:0] fixed, input bit rnd);
    logic [7:0] sum, b;
    logic [12:0] base;
    base = hdr[4] ? 13'h0 : {hdr[3:0], 9'h0};
    pulse_start();
    sum = hdr;
    send_byte(hdr);
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : fixed;
      push_byte(base + 13'(4*i), b);
      sum = sum + b;
      send_byte(b);
    end
`ifdef ENABLE_TABLE_CHECKSUM_EN
    send_byte(8'h00 - sum + ck_delta);
`endif
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, done, error, tbl_we} !== 5'b0)
      $display("FAIL reset_ctl: %b required 00000",
        {in_ready, busy, done, error, tbl_we});
    else passes++;
    checks++;
    if (tbl_addr !== 13'h0 || tbl_data !== 2'd0)
      $display("FAIL reset_tbl: %h/%0d required 0/0",
        tbl_addr, tbl_data);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL idle_ignore: rdy=%b busy=%b required 0",
        in_ready, busy);
    else passes++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_timing();
    logic [14:0] e, o;
    pulse_start();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL start_rdy: rdy=%b busy=%b required 1",
        in_ready, busy);
    else passes++;
    send_byte(8'h01);
    push_byte(13'h200, 8'h1B);
    send_byte(8'h1B);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (tbl_we !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL unpack_cyc%0d: we=%b rdy=%b required 1/0",
          k, tbl_we, in_ready);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (tbl_we !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reload_cyc: we=%b rdy=%b required 0/1",
        tbl_we, in_ready);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size())
        $display("FAIL timing_wr: missing, required %h", e);
      else begin
        o = obs_q[rd_idx];
        rd_idx++;
        if (o !== e)
          $display("FAIL timing_wr: got %h required %h", o, e);
        else passes++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_slice();
    logic [14:0] e, o;
    int d0, w0;
    d0 = done_cnt;
    w0 = wr_cnt;
    run_load(8'h03, 128, 8'hE4, 1'b0);
    checks++;
    if (done_cnt - d0 != 1 || error !== 1'b0 || busy !== 1'b0)
      $display("FAIL slice_done: done=%0d err=%b busy=%b required 1/0/0",
        done_cnt - d0, error, busy);
    else passes++;
    checks++;
`ifdef ENABLE_TABLE_CHECKSUM_EN
    if (done_cyc <= last_we_cyc + 1)
`else
    if (done_cyc != last_we_cyc + 1)
`endif
      $display("FAIL done_latency: %0d cycles after last write",
        done_cyc - last_we_cyc);
    else passes++;
    checks++;
    if (wr_cnt - w0 != 512)
      $display("FAIL slice_count: %0d required 512", wr_cnt - w0);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size())
        $display("FAIL slice_wr: missing, required %h", e);
      else begin
        o = obs_q[rd_idx];
        rd_idx++;
        if (o !== e)
          $display("FAIL slice_wr: got %h required %h", o, e);
        else passes++;
      end
    end
  endtask

  task automatic test_full();
    logic [14:0] e, o;
    int d0, w0, w1;
    d0 = done_cnt;
    w0 = wr_cnt;
    run_load(8'h10, 2048, 8'h55, 1'b0);
    w1 = wr_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cnt != w1 || w1 - w0 != 8192)
      $display("FAIL full_count: %0d+%0d required 8192+0",
        w1 - w0, wr_cnt - w1);
    else passes++;
    checks++;
    if (done_cnt - d0 != 1 || tbl_addr !== 13'h1FFF)
      $display("FAIL full_end: done=%0d addr=%h required 1/1fff",
        done_cnt - d0, tbl_addr);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size())
        $display("FAIL full_wr: missing, required %h", e);
      else begin
        o = obs_q[rd_idx];
        rd_idx++;
        if (o !== e)
          $display("FAIL full_wr: got %h required %h", o, e);
        else passes++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_bad_header();
    int w0;
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'h83);
    repeat (6) @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL bad_hdr: err=%b busy=%b rdy=%b required 1/0/0",
        error, busy, in_ready);
    else passes++;
    checks++;
    if (wr_cnt != w0)
      $display("FAIL bad_hdr_wr: %0d required 0", wr_cnt - w0);
    else passes++;
    @(posedge clk);
    #1;
    pulse_start();
    checks++;
    if (error !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL err_clear: err=%b rdy=%b required 0/1",
        error, in_ready);
    else passes++;
  endtask

  task automatic test_abort();
    logic [14:0] e, o;
    logic [7:0] b;
    int w0, d0;
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'h02);
    for (int i = 0; i < 10; i++) begin
      b = 8'(i * 37 + 5);
      push_byte(13'h400 + 13'(4*i), b);
      send_byte(b);
    end
    b = 8'hC6;
    exp_q.push_back({13'h428, b[1:0]});
    exp_q.push_back({13'h429, b[3:2]});
    send_byte(b);
    @(posedge clk);
    #1;
    pulse_start();
    repeat (8) @(negedge clk);
    checks++;
    if (wr_cnt - w0 != 42 || in_ready !== 1'b1)
      $display("FAIL abort_stop: %0d writes rdy=%b required 42/1",
        wr_cnt - w0, in_ready);
    else passes++;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    run_load(8'h05, 128, 8'h00, 1'b1);
    checks++;
    if (done_cnt - d0 != 1 || error !== 1'b0)
      $display("FAIL abort_reload: done=%0d err=%b required 1/0",
        done_cnt - d0, error);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size())
        $display("FAIL abort_wr: missing, required %h", e);
      else begin
        o = obs_q[rd_idx];
        rd_idx++;
        if (o !== e)
          $display("FAIL abort_wr: got %h required %h", o, e);
        else passes++;
      end
    end
  endtask

  task automatic test_stall_reset();
    logic [14:0] e, o;
    logic [7:0] b;
    int w0, w1;
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'h07);
    for (int i = 0; i < 5; i++) begin
      b = 8'(8'h3C + i * 11);
      push_byte(13'hE00 + 13'(4*i), b);
      send_byte(b);
      if (i == 2) begin
        repeat (6) @(negedge clk);
        w1 = wr_cnt;
        repeat (50) @(negedge clk);
        checks++;
        if (wr_cnt != w1 || in_ready !== 1'b1)
          $display("FAIL stall: %0d writes rdy=%b required 0/1",
            wr_cnt - w1, in_ready);
        else passes++;
        @(posedge clk);
        #1;
      end
    end
    b = 8'hA7;
    exp_q.push_back({13'hE14, b[1:0]});
    send_byte(b);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({tbl_we, in_ready, busy, done, error} !== 5'b0)
      $display("FAIL reset_mid: %b required 00000",
        {tbl_we, in_ready, busy, done, error});
    else passes++;
    checks++;
    if (tbl_addr !== 13'h0 || tbl_data !== 2'd0)
      $display("FAIL reset_mid_tbl: %h/%0d required 0/0",
        tbl_addr, tbl_data);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt - w0 != 21)
      $display("FAIL stall_count: %0d required 21", wr_cnt - w0);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size())
        $display("FAIL stall_wr: missing, required %h", e);
      else begin
        o = obs_q[rd_idx];
        rd_idx++;
        if (o !== e)
          $display("FAIL stall_wr: got %h required %h", o, e);
        else passes++;
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

`ifdef ENABLE_TABLE_CHECKSUM_EN
  task automatic test_checksum();
    logic [14:0] e, o;
    int d0;
    for (int pass = 0; pass < 2; pass++) begin
      d0 = done_cnt;
      ck_delta = 8'(pass);
      run_load(8'h00, 128, 8'h01, 1'b0);
      checks++;
      if (done_cnt - d0 != 1 - pass || error !== 1'(pass))
        $display("FAIL cksum%0d: done=%0d err=%b required %0d/%0d",
          pass, done_cnt - d0, error, 1 - pass, pass);
      else passes++;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rd_idx >= obs_q.size())
          $display("FAIL cksum_wr: missing, required %h", e);
        else begin
          o = obs_q[rd_idx];
          rd_idx++;
          if (o !== e)
            $display("FAIL cksum_wr: got %h required %h", o, e);
          else passes++;
        end
      end
    end
    ck_delta = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_slice();
    test_full();
    test_bad_header();
    test_abort();
    test_stall_reset();
`ifdef ENABLE_TABLE_CHECKSUM_EN
    test_checksum();
`endif
    checks++;
    if (rd_idx != obs_q.size())
      $display("FAIL extra_writes: %0d required 0",
        obs_q.size() - rd_idx);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/enable_table_writer.md
# enable_table_writer

Runtime loader for the RAM/bus enable table: accepts a byte stream from the host command interface and unpacks it into 2-bit enable entries written into the enable-table memory, the same memory the address decoder reads to drive cs_ram/cs_bus. A new memory map can be installed without rebuilding the bitstream. Loads either one 4-bit configuration slice (512 entries) or the whole table (8192 entries).

## Interface
- ADDR_ENTRY_BITS, 8, page-index bits (256-byte granularity over 64 KB)
- CONFIG_BITS, 4, configuration-index bits
- ENABLE_ADDR_BITS, ADDR_ENTRY_BITS+CONFIG_BITS+1 (13), table address width
- fpga_clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  one-cycle pulse: begin a load, next accepted byte is the header
- in_data  input  8  header / payload / checksum byte
- in_valid  input  1  in_data valid
- in_ready  output  1  writer can accept a byte; transfer when in_valid & in_ready
- tbl_we  output  1  enable-table write strobe
- tbl_addr  output  13  table address {config, rwbar, page}
- tbl_data  output  2  entry {ram_en, bus_en}
- busy  output  1  load in progress
- done  output  1  one-cycle pulse on successful completion
- error  output  1  sticky until next start: bad header or checksum mismatch

## Operation
- States: IDLE, HEADER, LOAD, UNPACK, CHECK (CHECK only with checksum), DONE.
- IDLE: in_ready=0, busy=0; in_valid ignored. start -> HEADER, clears error.
- HEADER: in_ready=1. Header byte: [3:0] config index, [4] all-configs flag, [7:5] reserved, must be 0. Reserved nonzero -> error=1, IDLE, no writes. Otherwise address counter = flag ? 0 : {cfg, 9'b0}; end address = flag ? 8191 : {cfg, 9'h1FF}; -> LOAD.
- LOAD: in_ready=1; accepted byte latched -> UNPACK.
- UNPACK: 4 cycles, in_ready=0, tbl_we=1 each cycle; cycle k writes bits [2k+1:2k] (LSB pair first) to tbl_addr, then increments tbl_addr. After write at end address: -> CHECK (checksum build) or DONE; else -> LOAD.
- DONE: done=1 for one cycle, -> IDLE.
- Address counter is 13-bit; a full load ends exactly at 8191, never wraps back to 0.
- start while busy: abort, no further writes, -> HEADER next cycle, error cleared.
- start coinciding with an accepted byte: start wins, byte discarded.
- in_valid deasserted mid-load: writer waits in LOAD indefinitely, no timeout.

## Timing
- Reset values: in_ready=0, busy=0, done=0, error=0, tbl_we=0, tbl_addr=0, tbl_data=0; state IDLE.
- start at edge N -> in_ready=1 from cycle N+1.
- Byte accepted at edge N -> tbl_we high cycles N+1..N+4, in_ready high again in cycle N+5. Throughput 1 byte per 5 cycles.
- tbl_we/tbl_addr/tbl_data registered; memory samples on the rising edge ending each write cycle.
- Slice load: 128 payload bytes, 512 writes; full load: 2048 bytes, 8192 writes.
- done asserts the cycle after the last write (or after checksum acceptance).
- Reset mid-load: tbl_we drops immediately (asynchronous); partially written table contents are left as is.

## Configuration
- ENABLE_TABLE_CHECKSUM_EN defined: after the last payload write -> CHECK, in_ready=1, one extra byte accepted. Pass: 8-bit sum of header + all payload + checksum byte == 0x00 -> DONE. Mismatch -> error=1, IDLE, no done. Table writes are not rolled back; host reloads.
- Undefined: no CHECK state, no checksum byte; DONE follows last write directly.

## Structure
- Shared package romulator_pkg: ADDR_ENTRY_BITS, CONFIG_BITS, ENABLE_ADDR_BITS, state encodings, header field positions. The decoder uses the same constants so table layout cannot diverge.
- One sub-module: enable_entry_unpacker. Holds the latched byte, 2-bit entry select, 4-cycle write sequencing. The FSM, address counter and checksum stay in the top.

## Test plan
- Reset then start, header 0x03, 128 bytes 0xE4 -> 512 writes, addr 0x0600..0x07FF, data cycling 0,1,2,3; done once; error=0.
- Header 0x10, 2048 bytes 0x55 -> 8192 writes addr 0..8191 all data 1; no write after 8191; done pulse.
- Header 0x83 -> error=1, zero tbl_we, IDLE; next start clears error.
- start pulsed after 10 payload bytes of config 2 -> writes stop, new header accepted, new load writes from its own base.
- ENABLE_TABLE_CHECKSUM_EN: header 0x00, 128 × 0x01, checksum 0x80 -> done. Same load with checksum 0x81 -> error=1, no done.
- in_valid stalled 50 cycles mid-load, and reset asserted mid-UNPACK -> stall produces no writes, then load resumes correctly; reset drops tbl_we the same cycle, all outputs return to reset values.
